// File: rtl/barrel_unshifter_seq.sv
// rtl/barrel_unshifter_seq.sv - sequential right-rotate that undoes a left barrel rotate
// One rotate step per clock; start/ready/done handshake with registered result.
module barrel_unshifter_seq #(
  parameter int WIDTH = 4,
  parameter int SW    = $clog2(WIDTH)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] data_in,
  input  logic [SW-1:0]    shamt,
  output logic             ready,
  output logic             done,
  output logic [WIDTH-1:0] data_out
);

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_ROTATE = 2'd1,
    S_DONE   = 2'd2
  } state_t;

  state_t           state;
  state_t           state_nxt;
  logic [WIDTH-1:0] sr;
  logic [WIDTH-1:0] sr_rot;
  logic [SW-1:0]    cnt;

  assign sr_rot = {sr[0], sr[WIDTH-1:1]};

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= S_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE: begin
        if (start) begin
          state_nxt = (shamt == '0) ? S_DONE : S_ROTATE;
        end
      end
      S_ROTATE: begin
        if (cnt == SW'(1)) begin
          state_nxt = S_DONE;
        end
      end
      S_DONE:  state_nxt = S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
  end

  always_comb begin
    ready = (state == S_IDLE);
    done  = (state == S_DONE);
  end

  // data_out is captured on the same edge that enters DONE, so it is valid with done
  always_ff @(posedge clk) begin
    if (rst) begin
      sr       <= '0;
      cnt      <= '0;
      data_out <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          if (start) begin
            sr  <= data_in;
            cnt <= shamt;
            if (shamt == '0) begin
              data_out <= data_in;
            end
          end
        end
        S_ROTATE: begin
          sr  <= sr_rot;
          cnt <= cnt - SW'(1);
          if (cnt == SW'(1)) begin
            data_out <= sr_rot;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_barrel_unshifter_seq.sv
// tb/tb_barrel_unshifter_seq.sv - scoreboard bench for barrel_unshifter_seq
module tb_barrel_unshifter_seq;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       start = 1'b0;
  logic [3:0] data_in = 4'd0;
  logic [1:0] shamt = 2'd0;
  logic       ready;
  logic       done;
  logic [3:0] data_out;

  int n_pass = 0;
  int n_total = 0;
  int cyc = 0;

  typedef struct {
    logic [3:0] d;
    int         c;
  } exp_t;
  exp_t q[$];

  barrel_unshifter_seq #(.WIDTH(4), .SW(2)) dut (
    .clk(clk), .rst(rst), .start(start), .data_in(data_in), .shamt(shamt),
    .ready(ready), .done(done), .data_out(data_out)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input int act, input int exp);
    n_total++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  function automatic logic [3:0] rotl(input logic [3:0] x, input int s);
    logic [7:0] t;
    t = {x, x} << s;
    return t[7:4];
  endfunction

  // monitor: every done pulse must match the oldest outstanding expectation
  always @(negedge clk) begin
    if (done) begin
      if (q.size() == 0) begin
        chk("unexpected_done", 1, 0);
      end else begin
        exp_t e;
        e = q.pop_front();
        chk("data_out", int'(data_out), int'(e.d));
        chk("latency", cyc, e.c);
      end
    end
  end

  task automatic wait_ready();
    int i;
    for (i = 0; i < 20 && !ready; i++) @(negedge clk);
    if (!ready) chk("ready_timeout", 0, 1);
  endtask

  task automatic issue(input logic [3:0] x, input int s, input logic [3:0] exp, input bit push);
    exp_t e;
    wait_ready();
    start   = 1'b1;
    data_in = x;
    shamt   = 2'(s);
    if (push) begin
      e.d = exp;
      e.c = cyc + 1 + s;
      q.push_back(e);
    end
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic drain();
    int i;
    for (i = 0; i < 60 && q.size() != 0; i++) @(negedge clk);
    if (q.size() != 0) chk("drain_timeout", q.size(), 0);
    @(negedge clk);
  endtask

  initial begin
    repeat (2) @(negedge clk);
    rst = 1'b0;
    chk("rst_ready", int'(ready), 1);
    chk("rst_done", int'(done), 0);
    chk("rst_data_out", int'(data_out), 0);

    issue(4'b0001, 0, 4'b0001, 1'b1);
    chk("s0_ready_low", int'(ready), 0);
    @(negedge clk);
    chk("s0_ready_back", int'(ready), 1);

    issue(4'b1000, 3, 4'b0001, 1'b1);
    drain();
    issue(4'b1001, 2, 4'b0110, 1'b1);
    drain();

    // start and data_in changes during ROTATE must be ignored
    issue(4'b1000, 3, 4'b0001, 1'b1);
    start = 1'b1; data_in = 4'b1111; shamt = 2'd1;
    @(negedge clk);
    start = 1'b0; data_in = 4'b1010;
    drain();

    // reset after one rotate aborts without a done pulse
    issue(4'b1010, 3, 4'b0000, 1'b0);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    chk("abort_ready", int'(ready), 1);
    chk("abort_done", int'(done), 0);
    chk("abort_data_out", int'(data_out), 0);
    repeat (6) @(negedge clk);
    issue(4'b1010, 1, 4'b0101, 1'b1);
    drain();

    for (int s = 0; s < 4; s++) begin
      issue(4'b0000, s, 4'b0000, 1'b1);
      issue(4'b1111, s, 4'b1111, 1'b1);
    end
    drain();

    // back-to-back round-trip sweep
    for (int a = 0; a < 16; a++) begin
      for (int s = 0; s < 4; s++) begin
        issue(rotl(4'(a), s), s, 4'(a), 1'b1);
      end
    end
    drain();

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
